// File: rtl/key_pkg.sv
// Shared constants and helpers for the multi-channel key conditioner.
// Clock-rate constants assume a 50 MHz system clock.
package key_pkg;

  // Debounce window of 20 ms (count of CNT_MAX+1 cycles).
  localparam int unsigned CNT_20MS_50M  = 32'd999_999;
  // Long-press threshold of 1 s.
  localparam int unsigned CNT_1S_50M    = 32'd49_999_999;
  // Auto-repeat period of 200 ms, minus one.
  localparam int unsigned CNT_200MS_50M = 32'd9_999_999;

  // Number of bits needed to count from 0 up to max_val inclusive (min 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    if (max_val < 32'd1) begin
      w = 32'd1;
    end else begin
      w = $clog2(max_val + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, symmetric debounce counter,
// registered press/release pulses and, when KEY_LONG_PRESS_EN is defined,
// a hold counter that emits long-press / auto-repeat pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX    = CNT_20MS_50M,
  parameter int unsigned ACTIVE_LOW = 32'd1,
  parameter int unsigned LONG_MAX   = CNT_1S_50M,
  parameter int unsigned REPEAT_MAX = CNT_200MS_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic press_flag,
  output logic release_flag,
  output logic long_flag
);

  localparam int unsigned      CNT_W    = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  // Pin level of a released key; the synchroniser starts here so that a
  // key held through reset is seen as a fresh press.
  localparam logic             IDLE_LVL = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;

  // Repeat period must fit inside the long-press threshold.
  if ((REPEAT_MAX < 32'd1) || (REPEAT_MAX > LONG_MAX)) begin : g_bad_cfg
    $error("key_debounce_ch: need 1 <= REPEAT_MAX <= LONG_MAX");
  end

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             act;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_state_q, key_state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Synchroniser shift, polarity normalisation and debounce decision.
  always_comb begin
    s1_d        = key_in;
    s2_d        = s1_q;
    act         = (ACTIVE_LOW != 32'd0) ? ~s2_q : s2_q;
    cnt_d       = cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    if (act == key_state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      key_state_d = act;
      cnt_d       = '0;
      press_d     = act;
      release_d   = ~act;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, debounce counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= IDLE_LVL;
      s2_q        <= IDLE_LVL;
      cnt_q       <= '0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign key_state    = key_state_q;
  assign press_flag   = press_q;
  assign release_flag = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned       HOLD_W      = cnt_width(LONG_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(LONG_MAX);
  // After the first long pulse the counter restarts here so that the next
  // pulse comes REPEAT_MAX+1 cycles later.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LONG_MAX - REPEAT_MAX);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Hold-time counting; a release transition clears it so no long pulse
  // can land on the same cycle as release_flag.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!key_state_q || release_d) begin
      hold_d = '0;
    end else if (hold_q == HOLD_LAST) begin
      long_d = 1'b1;
      hold_d = HOLD_RELOAD;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_flag = long_q;
`else
  assign long_flag = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: NUM_KEYS independent copies of
// key_debounce_ch. Optional long-press/auto-repeat pulses are built when
// the macro KEY_LONG_PRESS_EN is defined; otherwise long_flag reads 0.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 32'd4,
  parameter int unsigned CNT_MAX    = CNT_20MS_50M,
  parameter int unsigned ACTIVE_LOW = 32'd1,
  parameter int unsigned LONG_MAX   = CNT_1S_50M,
  parameter int unsigned REPEAT_MAX = CNT_200MS_50M
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_flag,
  output logic [NUM_KEYS-1:0] release_flag,
  output logic [NUM_KEYS-1:0] long_flag
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX   (CNT_MAX),
      .ACTIVE_LOW(ACTIVE_LOW),
      .LONG_MAX  (LONG_MAX),
      .REPEAT_MAX(REPEAT_MAX)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .key_state   (key_state[i]),
      .press_flag  (press_flag[i]),
      .release_flag(release_flag[i]),
      .long_flag   (long_flag[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with CNT_MAX=4, LONG_MAX=10,
// REPEAT_MAX=3, ACTIVE_LOW=1. Long-press expectations follow
// KEY_LONG_PRESS_EN.
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] press_flag;
  logic [3:0] release_flag;
  logic [3:0] long_flag;

  int n_checks = 0;
  int n_pass   = 0;

  key_debounce_multi #(
    .NUM_KEYS  (4),
    .CNT_MAX   (4),
    .ACTIVE_LOW(1),
    .LONG_MAX  (10),
    .REPEAT_MAX(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .press_flag  (press_flag),
    .release_flag(release_flag),
    .long_flag   (long_flag)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are stable 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    key_in = 4'hF;
    repeat (3) tick();
    n_checks++;
    if ({key_state, press_flag, release_flag, long_flag} !== 16'h0000)
      $display("FAIL reset_held outs=%h exp=0000",
               {key_state, press_flag, release_flag, long_flag});
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if ({key_state, press_flag, release_flag, long_flag} !== 16'h0000)
        $display("FAIL reset_idle c=%0d outs=%h exp=0000", c,
                 {key_state, press_flag, release_flag, long_flag});
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_ks, exp_pf;
    key_in[0] = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_ks = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_pf = (e == 6) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (key_state !== exp_ks || press_flag !== exp_pf || release_flag !== 4'b0000)
        $display("FAIL clean_press e=%0d ks=%b pf=%b rf=%b exp ks=%b pf=%b rf=0000",
                 e, key_state, press_flag, release_flag, exp_ks, exp_pf);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_ks, exp_pf;
    // low 3, high 1: too short to register
    key_in[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) key_in[1] = 1'b1;
      tick();
      n_checks++;
      if (press_flag !== 4'b0000 || key_state !== 4'b0001)
        $display("FAIL bounce_glitch c=%0d pf=%b ks=%b exp pf=0000 ks=0001",
                 c, press_flag, key_state);
      else n_pass++;
    end
    // final fall, then held low
    key_in[1] = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_ks = (e >= 6) ? 4'b0011 : 4'b0001;
      exp_pf = (e == 6) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (key_state !== exp_ks || press_flag !== exp_pf || release_flag !== 4'b0000)
        $display("FAIL bounce_press e=%0d ks=%b pf=%b rf=%b exp ks=%b pf=%b rf=0000",
                 e, key_state, press_flag, release_flag, exp_ks, exp_pf);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [3:0] exp_ks, exp_rf;
    key_in[0] = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_ks = (e >= 6) ? 4'b0010 : 4'b0011;
      exp_rf = (e == 6) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (key_state !== exp_ks || release_flag !== exp_rf || press_flag !== 4'b0000)
        $display("FAIL release e=%0d ks=%b rf=%b pf=%b exp ks=%b rf=%b pf=0000",
                 e, key_state, release_flag, press_flag, exp_ks, exp_rf);
      else n_pass++;
    end
  endtask

  // Key 2 pressed at E0 so K = E0+6; long pulses at K+11, K+15, K+19.
  // Pin released right after K+15, so key_state falls at K+22 and the
  // K+23 pulse must not appear.
  task automatic test_long_press();
    logic exp_ks, exp_pf, exp_rf, exp_lf;
    key_in[2] = 1'b0;
    for (int t = 0; t <= 36; t++) begin
      tick();
      exp_ks = (t >= 6) && (t < 28);
      exp_pf = (t == 6);
      exp_rf = (t == 28);
`ifdef KEY_LONG_PRESS_EN
      exp_lf = (t == 17) || (t == 21) || (t == 25);
`else
      exp_lf = 1'b0;
`endif
      n_checks++;
      if (key_state[2] !== exp_ks || press_flag[2] !== exp_pf ||
          release_flag[2] !== exp_rf || long_flag[2] !== exp_lf)
        $display("FAIL long_press t=%0d ks=%b pf=%b rf=%b lf=%b exp ks=%b pf=%b rf=%b lf=%b",
                 t, key_state[2], press_flag[2], release_flag[2], long_flag[2],
                 exp_ks, exp_pf, exp_rf, exp_lf);
      else n_pass++;
`ifndef KEY_LONG_PRESS_EN
      n_checks++;
      if (long_flag !== 4'b0000)
        $display("FAIL long_off t=%0d lf=%b exp=0000", t, long_flag);
      else n_pass++;
`endif
      if (t == 21) key_in[2] = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_ks, exp_pf, exp_rf;
    // settle everything released
    key_in = 4'hF;
    repeat (10) tick();
    n_checks++;
    if (key_state !== 4'h0)
      $display("FAIL all_released ks=%b exp=0000", key_state);
    else n_pass++;
    // press all four on the same edge
    key_in = 4'h0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_ks = (e >= 6) ? 4'hF : 4'h0;
      exp_pf = (e == 6) ? 4'hF : 4'h0;
      n_checks++;
      if (key_state !== exp_ks || press_flag !== exp_pf)
        $display("FAIL simul_press e=%0d ks=%b pf=%b exp ks=%b pf=%b",
                 e, key_state, press_flag, exp_ks, exp_pf);
      else n_pass++;
    end
    // release all four on the same edge
    key_in = 4'hF;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_ks = (e >= 6) ? 4'h0 : 4'hF;
      exp_rf = (e == 6) ? 4'hF : 4'h0;
      n_checks++;
      if (key_state !== exp_ks || release_flag !== exp_rf)
        $display("FAIL simul_release e=%0d ks=%b rf=%b exp ks=%b rf=%b",
                 e, key_state, release_flag, exp_ks, exp_rf);
      else n_pass++;
    end
    // press again, reset mid-debounce with keys still held
    key_in = 4'h0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({key_state, press_flag, release_flag, long_flag} !== 16'h0000)
      $display("FAIL mid_reset outs=%h exp=0000",
               {key_state, press_flag, release_flag, long_flag});
    else n_pass++;
    rst = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      exp_ks = (n >= 7) ? 4'hF : 4'h0;
      exp_pf = (n == 7) ? 4'hF : 4'h0;
      n_checks++;
      if (key_state !== exp_ks || press_flag !== exp_pf || release_flag !== 4'h0)
        $display("FAIL post_reset n=%0d ks=%b pf=%b rf=%b exp ks=%b pf=%b rf=0000",
                 n, key_state, press_flag, release_flag, exp_ks, exp_pf);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_long_press();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
